// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding and iteration-counter sizing.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int DEF_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int xlen);
        return (xlen > 1) ? $clog2(xlen) : 1;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Two-channel conditional negation: yields |x| for operand conditioning
// and re-applies the sign to results.
module muldiv_sign_fix #(
    parameter int WA = 32,
    parameter int WB = 32
) (
    input  logic [WA-1:0] a,
    input  logic [WB-1:0] b,
    input  logic          neg_a,
    input  logic          neg_b,
    output logic [WA-1:0] y_a,
    output logic [WB-1:0] y_b
);

    assign y_a = neg_a ? (~a + WA'(1)) : a;
    assign y_b = neg_b ? (~b + WB'(1)) : b;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply (radix-2 shift-add) / divide (radix-2 restoring) unit.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier is zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            w_en,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = cnt_width(XLEN);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc, opnd;
    logic [XLEN-1:0]   mplier;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              res_neg;

    logic signed [XLEN-1:0] a_s, b_s;
    logic              is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in, res_neg_in;
    logic              div0, ovf, special, accept;
    logic [XLEN-1:0]   abs_a, abs_b, special_val;

    assign a_s        = op_a;
    assign b_s        = op_b;
    assign is_div_in  = funct3[2];
    assign a_sgn_in   = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                        (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign b_sgn_in   = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign a_neg_in   = a_sgn_in && (a_s < 0);
    assign b_neg_in   = b_sgn_in && (b_s < 0);
    // Remainder takes the dividend's sign; quotient and products take the xor.
    assign res_neg_in = (is_div_in && funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);

    assign div0    = is_div_in && (op_b == '0);
    assign ovf     = is_div_in && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (op_b == {XLEN{1'b1}});
    assign special = div0 || ovf;
    assign accept  = (state == ST_IDLE) && start;

    always_comb begin
        special_val = '0;
        if (div0)
            special_val = funct3[1] ? op_a : {XLEN{1'b1}};
        else
            special_val = funct3[1] ? '0 : op_a;
    end

    muldiv_sign_fix #(.WA(XLEN), .WB(XLEN)) u_opnd_fix (
        .a     (op_a),
        .b     (op_b),
        .neg_a (a_neg_in),
        .neg_b (b_neg_in),
        .y_a   (abs_a),
        .y_b   (abs_b)
    );

    logic [2*XLEN:0]   div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_acc, mul_acc, acc_it;
    logic [XLEN-1:0]   mplier_shift;
    logic              last_iter, calc_end;

    always_comb begin
        div_shift = {acc, 1'b0};
        div_diff  = div_shift[2*XLEN:XLEN] - {1'b0, opnd[XLEN-1:0]};
        div_acc   = div_diff[XLEN] ? div_shift[2*XLEN-1:0]
                                   : {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
        mul_acc   = acc + (mplier[0] ? opnd : '0);
        acc_it    = f3_q[2] ? div_acc : mul_acc;
    end

    assign mplier_shift = mplier >> 1;
    assign last_iter    = (cnt == CNT_W'(XLEN-1));
`ifdef MULDIV_EARLY_OUT_EN
    assign calc_end = last_iter || (!f3_q[2] && (mplier_shift == '0));
`else
    assign calc_end = last_iter;
`endif

    logic [XLEN-1:0]   div_val, div_fix, res_final;
    logic [2*XLEN-1:0] mul_fix;

    assign div_val = f3_q[1] ? acc_it[2*XLEN-1:XLEN] : acc_it[XLEN-1:0];

    muldiv_sign_fix #(.WA(2*XLEN), .WB(XLEN)) u_res_fix (
        .a     (acc_it),
        .b     (div_val),
        .neg_a (res_neg),
        .neg_b (res_neg),
        .y_a   (mul_fix),
        .y_b   (div_fix)
    );

    always_comb begin
        res_final = div_fix;
        if (!f3_q[2])
            res_final = (f3_q[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (flush)         state_nxt = ST_IDLE;
                else if (calc_end) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control and architecturally visible outputs: async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CALC) cnt <= cnt + 1'b1;
            else                  cnt <= '0;
            if (accept && special) begin
                result <= special_val;
                rd_out <= rd_in;
            end else if ((state == ST_CALC) && !flush && calc_end) begin
                result <= res_final;
                rd_out <= rd_q;
            end
        end
    end

    // Datapath: loaded on acceptance, stepped once per CALC cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            f3_q    <= funct3;
            rd_q    <= rd_in;
            res_neg <= res_neg_in;
            acc     <= is_div_in ? {{XLEN{1'b0}}, abs_a} : '0;
            opnd    <= is_div_in ? {{XLEN{1'b0}}, abs_b} : {{XLEN{1'b0}}, abs_a};
            mplier  <= abs_b;
        end else if (state == ST_CALC) begin
            acc     <= acc_it;
            opnd    <= f3_q[2] ? opnd : (opnd << 1);
            mplier  <= mplier_shift;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign w_en = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, flush, busy, done, w_en;
    logic [2:0]  funct3;
    logic [4:0]  rd_in, rd_out;
    logic [31:0] op_a, op_b, result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .rd_in  (rd_in),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .w_en   (w_en),
        .rd_out (rd_out),
        .result (result)
    );

    // Issues one request and waits (bounded) for done; optionally pulses a
    // second start with op_a=9, rd_in=9 at cycle inject_at.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int inject_at,
                          output int lat, output logic [31:0] res, output logic [4:0] rdo,
                          output logic wen, output int wen_total);
        lat = -1; res = '0; rdo = '0; wen = 1'b0; wen_total = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (n == inject_at) begin
                start = 1'b1; op_a = 32'd9; rd_in = 5'd9;
            end
            if (w_en) wen_total++;
            if (done) begin
                lat = n; res = result; rdo = rd_out; wen = w_en;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; rd_in = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (w_en !== 1'b0)    begin failures++; $display("FAIL reset_wen got=%b exp=0", w_en); end
        checks++; if (rd_out !== 5'd0)  begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd_out); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        int lat, wt; logic [31:0] res; logic [4:0] rdo; logic wen;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
        checks++; if (rdo !== 5'd5)          begin failures++; $display("FAIL mul_rd got=%0d exp=5", rdo); end
        checks++; if (wen !== 1'b1)          begin failures++; $display("FAIL mul_wen got=%b exp=1", wen); end
`ifndef MULDIV_EARLY_OUT_EN
        checks++; if (lat != 33)             begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
`else
        checks++; if (lat < 2 || lat > 33)   begin failures++; $display("FAIL mul_latency got=%0d exp=2..33", lat); end
`endif
        checks++; if (wt != 1)               begin failures++; $display("FAIL mul_wen_count got=%0d exp=1", wt); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL mul_after_done got done=%b busy=%b exp=0,0", done, busy);
        end
        checks++; if (result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_hold got=%h exp=ffffffeb", result); end
    endtask

    task automatic test_mul_high();
        int lat, wt; logic [31:0] res; logic [4:0] rdo; logic wen;
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'h4000_0000) begin failures++; $display("FAIL mulh got=%h exp=40000000", res); end
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu got=%h exp=fffffffe", res); end
        run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu got=%h exp=ffffffff", res); end
    endtask

    task automatic test_div();
        int lat, wt; logic [31:0] res; logic [4:0] rdo; logic wen;
        run_op(3'b101, 32'd100, 32'd7, 5'd4, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'd14) begin failures++; $display("FAIL divu got=%h exp=0000000e", res); end
        checks++; if (lat != 33)      begin failures++; $display("FAIL divu_latency got=%0d exp=33", lat); end
        run_op(3'b111, 32'd100, 32'd7, 5'd4, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'd2)  begin failures++; $display("FAIL remu got=%h exp=00000002", res); end
        run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd4, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'hFFFF_FFF2) begin failures++; $display("FAIL div_neg got=%h exp=fffffff2", res); end
        run_op(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd4, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'hFFFF_FFFE) begin failures++; $display("FAIL rem_neg got=%h exp=fffffffe", res); end
    endtask

    task automatic test_div_special();
        int lat, wt; logic [31:0] res; logic [4:0] rdo; logic wen;
        run_op(3'b100, 32'h1234, 32'd0, 5'd6, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'hFFFF_FFFF || lat != 1) begin
            failures++; $display("FAIL div_by_zero got=%h lat=%0d exp=ffffffff lat=1", res, lat);
        end
        run_op(3'b110, 32'h1234, 32'd0, 5'd6, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'h1234 || lat != 1) begin
            failures++; $display("FAIL rem_by_zero got=%h lat=%0d exp=00001234 lat=1", res, lat);
        end
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'h8000_0000 || lat != 1) begin
            failures++; $display("FAIL div_overflow got=%h lat=%0d exp=80000000 lat=1", res, lat);
        end
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'd0 || lat != 1) begin
            failures++; $display("FAIL rem_overflow got=%h lat=%0d exp=00000000 lat=1", res, lat);
        end
        checks++; if (rdo !== 5'd6 || wen !== 1'b1) begin
            failures++; $display("FAIL special_wb got rd=%0d wen=%b exp=6,1", rdo, wen);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'd3; rd_in = 5'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL rst_mid_result got=%h exp=0", result); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || w_en) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen); end
    endtask

    task automatic test_flush();
        int lat, wt, seen; logic [31:0] res; logic [4:0] rdo; logic wen;
        run_op(3'b000, 32'd5, 32'd5, 5'd7, 0, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'd25) begin failures++; $display("FAIL flush_pre got=%h exp=00000019", res); end
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || w_en) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        checks++; if (result !== 32'd25 || rd_out !== 5'd7) begin
            failures++; $display("FAIL flush_hold got=%h rd=%0d exp=00000019 rd=7", result, rd_out);
        end
    endtask

    task automatic test_back_to_back();
        int lat, wt; logic [31:0] res; logic [4:0] rdo; logic wen;
        run_op(3'b000, 32'd6, 32'd7, 5'd4, 5, lat, res, rdo, wen, wt);
        checks++; if (res !== 32'd42 || rdo !== 5'd4) begin
            failures++; $display("FAIL b2b_first got=%h rd=%0d exp=0000002a rd=4", res, rdo);
        end
`ifndef MULDIV_EARLY_OUT_EN
        checks++; if (lat != 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
`endif
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    endtask

    task automatic test_rd_zero();
        int lat, wt; logic [31:0] res; logic [4:0] rdo; logic wen;
        run_op(3'b000, 32'd2, 32'd3, 5'd0, 0, lat, res, rdo, wen, wt);
        checks++; if (lat < 1) begin failures++; $display("FAIL rd0_done got=%0d exp=done seen", lat); end
        checks++; if (wen !== 1'b0 || wt != 0) begin
            failures++; $display("FAIL rd0_wen got=%b count=%0d exp=0", wen, wt);
        end
        checks++; if (res !== 32'd6) begin failures++; $display("FAIL rd0_result got=%h exp=00000006", res); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_div_special();
        test_reset_mid();
        test_flush();
        test_back_to_back();
        test_rd_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
